// File: rtl/led_pattern_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : led_pattern_ctrl
//  Description : Steps one of four LED patterns on a 4-LED active-low bank,
//                one step per clk_1s edge. Mode changes arrive through a
//                valid/ready handshake and take effect only at pattern
//                boundaries. A level pause input holds the current step.
//  Ports       : clk_1s     - step clock (one edge = one pattern step)
//                rst_n      - asynchronous active-low reset
//                req_valid  - mode-change request valid
//                req_mode   - requested mode (sampled on accept)
//                req_ready  - high when no request is pending
//                pause      - level, holds the pattern while high
//                led        - LED drive, active-low (0 = lit)
//                mode       - mode currently displayed
//                step       - index of the step currently on led
//                running    - high in RUN state
//                mode_ack   - one-cycle pulse on the edge a mode is applied
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
    parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
    input  logic       clk_1s,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    input  logic       pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [2:0] step,
    output logic       running,
    output logic       mode_ack
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_PAUSED = 2'd2;

    localparam logic [3:0] c_LED_OFF = 4'b1111;

    // Pattern lookup: LED drive for a given mode and step.
    function automatic logic [3:0] f_pattern(input logic [1:0] m, input logic [2:0] s);
        logic [3:0] v;
        v = c_LED_OFF;
        case (m)
            2'd0: begin
                case (s)
                    3'd0:    v = 4'b0111;
                    3'd1:    v = 4'b1011;
                    3'd2:    v = 4'b1101;
                    default: v = 4'b1110;
                endcase
            end
            2'd1: begin
                case (s)
                    3'd0:    v = 4'b1110;
                    3'd1:    v = 4'b1101;
                    3'd2:    v = 4'b1011;
                    default: v = 4'b0111;
                endcase
            end
            2'd2: begin
                v = (s == 3'd0) ? 4'b0000 : 4'b1111;
            end
            default: begin
                case (s)
                    3'd0:    v = 4'b0111;
                    3'd1:    v = 4'b1011;
                    3'd2:    v = 4'b1101;
                    3'd3:    v = 4'b1110;
                    3'd4:    v = 4'b1101;
                    default: v = 4'b1011;
                endcase
            end
        endcase
        return v;
    endfunction

    // Index of the final step of each pattern (length - 1).
    function automatic logic [2:0] f_last_step(input logic [1:0] m);
        logic [2:0] v;
        case (m)
            2'd0:    v = 3'd3;
            2'd1:    v = 3'd3;
            2'd2:    v = 3'd1;
            default: v = 3'd5;
        endcase
        return v;
    endfunction

    logic [1:0] r_state;
    logic [1:0] r_mode;
    logic [2:0] r_step;
    logic [3:0] r_led;
    logic       r_mode_ack;
    logic       r_pend_valid;
    logic [1:0] r_pend_mode;

    logic [1:0] w_state_nxt;
    logic [1:0] w_mode_nxt;
    logic [2:0] w_step_nxt;
    logic [3:0] w_led_nxt;
    logic       w_mode_ack_nxt;
    logic       w_pend_valid_nxt;
    logic [1:0] w_pend_mode_nxt;

    logic       w_boundary;
    logic       w_accept;
    logic [1:0] w_start_mode;
    logic [2:0] w_step_inc;

    assign w_boundary   = (r_step == f_last_step(r_mode));
    // The handshake only runs once the sequencer has left IDLE; in IDLE a
    // request is consumed directly on the start edge instead.
    assign w_accept     = req_valid && !r_pend_valid && (r_state != c_ST_IDLE);
    assign w_start_mode = req_valid ? req_mode : r_mode;
    assign w_step_inc   = w_boundary ? 3'd0 : (r_step + 3'd1);

    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_step_nxt       = r_step;
        w_led_nxt        = r_led;
        w_mode_ack_nxt   = 1'b0;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_mode_nxt  = r_pend_mode;

        case (r_state)
            c_ST_IDLE: begin
                if (!pause) begin
                    w_state_nxt    = c_ST_RUN;
                    w_mode_nxt     = w_start_mode;
                    w_mode_ack_nxt = req_valid;
                    w_step_nxt     = 3'd0;
                    w_led_nxt      = f_pattern(w_start_mode, 3'd0);
                end
            end
            default: begin
                // RUN and PAUSED share the advance rules; a resume from
                // PAUSED advances on the same edge pause is seen low.
                if (pause) begin
                    w_state_nxt = c_ST_PAUSED;
                end else begin
                    w_state_nxt = c_ST_RUN;
                    // Only a request pending before this edge may apply, so a
                    // request accepted on a boundary waits a full pattern.
                    if (w_boundary && r_pend_valid) begin
                        w_mode_nxt       = r_pend_mode;
                        w_step_nxt       = 3'd0;
                        w_led_nxt        = f_pattern(r_pend_mode, 3'd0);
                        w_mode_ack_nxt   = 1'b1;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        w_step_nxt = w_step_inc;
                        w_led_nxt  = f_pattern(r_mode, w_step_inc);
                    end
                end
                // Accept requires no pending entry, so it never collides with
                // the clear above.
                if (w_accept) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_mode_nxt  = req_mode;
                end
            end
        endcase
    end

    always_ff @(posedge clk_1s or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_mode       <= DEFAULT_MODE;
            r_step       <= 3'd0;
            r_led        <= c_LED_OFF;
            r_mode_ack   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_mode  <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_step       <= w_step_nxt;
            r_led        <= w_led_nxt;
            r_mode_ack   <= w_mode_ack_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_mode  <= w_pend_mode_nxt;
        end
    end

    // All outputs come straight from flops (ready/running via one gate each).
    assign led       = r_led;
    assign mode      = r_mode;
    assign step      = r_step;
    assign mode_ack  = r_mode_ack;
    assign req_ready = ~r_pend_valid;
    assign running   = (r_state == c_ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_led_pattern_ctrl
//  Description : Directed self-checking bench for led_pattern_ctrl with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

    logic       clk_1s;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;
    logic       pause;
    logic [3:0] led;
    logic [1:0] mode;
    logic [2:0] step;
    logic       running;
    logic       mode_ack;

    int n_vec;
    int n_err;

    led_pattern_ctrl #(
        .DEFAULT_MODE (2'd0)
    ) dut (
        .clk_1s    (clk_1s),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .pause     (pause),
        .led       (led),
        .mode      (mode),
        .step      (step),
        .running   (running),
        .mode_ack  (mode_ack)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one step and sample 1 ns after the active edge.
    task automatic tick;
        @(posedge clk_1s);
        #1;
    endtask

    task automatic chk_run(input string tag, input logic [3:0] e_led, input logic [2:0] e_step,
                           input logic [1:0] e_mode, input logic e_ack);
        check_eq({tag, ".led"},  {4'd0, led},     {4'd0, e_led});
        check_eq({tag, ".step"}, {5'd0, step},    {5'd0, e_step});
        check_eq({tag, ".mode"}, {6'd0, mode},    {6'd0, e_mode});
        check_eq({tag, ".ack"},  {7'd0, mode_ack}, {7'd0, e_ack});
    endtask

    // Watchdog: the sequence is fixed-length, so any overrun is a fault.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [3:0] exp_led [6];

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        pause     = 1'b0;
        req_valid = 1'b0;
        req_mode  = 2'd0;

        // Reset state (posedge at 5 passes while reset is held).
        #8;
        check_eq("rst.led",     {4'd0, led},      8'h0f);
        check_eq("rst.mode",    {6'd0, mode},     8'h00);
        check_eq("rst.step",    {5'd0, step},     8'h00);
        check_eq("rst.running", {7'd0, running},  8'h00);
        check_eq("rst.ready",   {7'd0, req_ready}, 8'h01);
        check_eq("rst.ack",     {7'd0, mode_ack}, 8'h00);
        #4 rst_n = 1'b1;

        // Default mode 0, five edges.
        exp_led[0] = 4'b0111; exp_led[1] = 4'b1011; exp_led[2] = 4'b1101;
        exp_led[3] = 4'b1110; exp_led[4] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_run("m0", exp_led[i], 3'(i % 4), 2'd0, 1'b0);
            check_eq("m0.running", {7'd0, running}, 8'h01);
        end

        // Request mode 3 while at step 1.
        tick();
        chk_run("m0s1", 4'b1011, 3'd1, 2'd0, 1'b0);
        req_valid = 1'b1; req_mode = 2'd3;
        tick();
        chk_run("acc", 4'b1101, 3'd2, 2'd0, 1'b0);
        check_eq("acc.ready", {7'd0, req_ready}, 8'h00);
        req_valid = 1'b0;
        tick();
        chk_run("pre_apply", 4'b1110, 3'd3, 2'd0, 1'b0);
        tick();
        chk_run("apply3", 4'b0111, 3'd0, 2'd3, 1'b1);
        check_eq("apply3.ready", {7'd0, req_ready}, 8'h01);

        // Ping-pong table, steps 1..5 then wrap.
        exp_led[0] = 4'b1011; exp_led[1] = 4'b1101; exp_led[2] = 4'b1110;
        exp_led[3] = 4'b1101; exp_led[4] = 4'b1011; exp_led[5] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_run("m3", exp_led[i], 3'(i + 1), 2'd3, 1'b0);
        end

        // At step 5: accept on the boundary edge, must not apply there.
        req_valid = 1'b1; req_mode = 2'd2;
        tick();
        chk_run("bnd_acc", 4'b0111, 3'd0, 2'd3, 1'b0);
        check_eq("bnd_acc.ready", {7'd0, req_ready}, 8'h00);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_run("m3b", exp_led[i], 3'(i + 1), 2'd3, 1'b0);
        end
        tick();
        chk_run("apply2", 4'b0000, 3'd0, 2'd2, 1'b1);

        // Pause on mode 2 at led 0000 for three edges.
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_run("pause", 4'b0000, 3'd0, 2'd2, 1'b0);
            check_eq("pause.running", {7'd0, running}, 8'h00);
        end
        pause = 1'b0;
        tick();
        chk_run("resume", 4'b1111, 3'd1, 2'd2, 1'b0);
        check_eq("resume.running", {7'd0, running}, 8'h01);

        // Second request while pending is ignored.
        req_valid = 1'b1; req_mode = 2'd0;
        tick();
        chk_run("p1", 4'b0000, 3'd0, 2'd2, 1'b0);
        check_eq("p1.ready", {7'd0, req_ready}, 8'h00);
        req_mode = 2'd1;
        tick();
        chk_run("p2", 4'b1111, 3'd1, 2'd2, 1'b0);
        tick();
        chk_run("p_apply", 4'b0111, 3'd0, 2'd0, 1'b1);
        req_valid = 1'b0;
        tick();
        chk_run("p_after", 4'b1011, 3'd1, 2'd0, 1'b0);

        // Reset mid-pattern with a request pending.
        req_valid = 1'b1; req_mode = 2'd3;
        tick();
        check_eq("r_pend.ready", {7'd0, req_ready}, 8'h00);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.led",     {4'd0, led},       8'h0f);
        check_eq("arst.mode",    {6'd0, mode},      8'h00);
        check_eq("arst.step",    {5'd0, step},      8'h00);
        check_eq("arst.ready",   {7'd0, req_ready}, 8'h01);
        check_eq("arst.running", {7'd0, running},   8'h00);
        tick();
        #2 rst_n = 1'b1;
        exp_led[0] = 4'b0111; exp_led[1] = 4'b1011; exp_led[2] = 4'b1101;
        exp_led[3] = 4'b1110; exp_led[4] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_run("post_rst", exp_led[i], 3'(i % 4), 2'd0, 1'b0);
        end

        // IDLE: pause holds LEDs dark; start with a request consumes it directly.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        pause = 1'b1;
        tick();
        check_eq("idle.led",     {4'd0, led},     8'h0f);
        check_eq("idle.running", {7'd0, running}, 8'h00);
        pause = 1'b0; req_valid = 1'b1; req_mode = 2'd1;
        tick();
        chk_run("idle_req", 4'b1110, 3'd0, 2'd1, 1'b1);
        check_eq("idle_req.ready", {7'd0, req_ready}, 8'h01);
        req_valid = 1'b0;
        tick();
        chk_run("m1", 4'b1101, 3'd1, 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
